noc_rx_injector: RTL and testbench
==================================

# noc_rx_injector

Host-side injector feeding the root of the upward PE tree's receive port. Accepts 16-bit words from the custom configuration bus when addressed, buffers them, and serializes each word MSB-first as 2-bit symbols over the four-phase req/data/ack link (`pr`/`pd`/`pa`) that drives a PE's `rx_pr`/`rx_pd`/`rx_pa`. Contains the only clocked-to-handshake crossing on this path: `pa` returns from self-timed logic and is synchronized here.

## Interface
- `NOC_WID`, 16: word width; must be even.
- `REGIONAL_ADDR_WID`, 11: config address width.
- `FIFO_DEPTH`, 4: word buffer depth; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `cfg_dat`  in  NOC_WID  bus write data.
- `cfg_adr`  in  REGIONAL_ADDR_WID  bus address.
- `cfg_stb`  in  1  bus write strobe, one cycle per write.
- `slv_addr`  in  REGIONAL_ADDR_WID  this injector's data address; `slv_addr+1` is its control address.
- `pr`  out  1  symbol request to PE `rx_pr`.
- `pd`  out  2  symbol data to PE `rx_pd`.
- `pa`  in  1  symbol acknowledge from PE `rx_pa`; asynchronous.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `ovf`  out  1  sticky: a data write was dropped.

## Operation
- Data write: `cfg_stb && cfg_adr==slv_addr`. FIFO not full → push `cfg_dat`; full → drop and set `ovf`.
- Control write: `cfg_stb && cfg_adr==slv_addr+1` clears `ovf`, data ignored. Clear and a simultaneous drop in the same cycle cannot occur, since the addresses differ.
- `pa` passes through a two-flop synchronizer to produce `pa_s`. The FSM uses only `pa_s`.
- FSM states:
  - IDLE: `pr=0`, `pd=0`. If FIFO non-empty: pop into shift register, load symbol counter `NOC_WID/2-1`, → SETUP.
  - SETUP: `pd` = shift register top 2 bits, `pr=0`. One cycle, → REQ.
  - REQ: `pr=1`, `pd` held. Wait `pa_s==1`, → RELEASE.
  - RELEASE: `pr=0`, `pd` held. Wait `pa_s==0`. Then: counter==0 → IDLE; else shift left by 2, decrement, → SETUP.
- Symbol order: bits `[NOC_WID-1:NOC_WID-2]` first, `[1:0]` last.
- `pd` never changes while `pr=1` or while `pa_s=1`.
- FIFO push and pop in the same cycle are legal when the FIFO is full or empty. Capacity while stalled is `FIFO_DEPTH` plus one in the shift register.
- `pa` high while in IDLE/SETUP is a protocol error. The FSM must not advance on it; REQ still requires `pa_s` to be seen, which is legal only after a prior low.
- Reset asynchronous to all state:
  - `pr`, `pd`, `busy`, `ovf` = 0.
  - FIFO empty, FSM IDLE, synchronizer flops 0.
  - Reset mid-word aborts the word; the downstream node is reset by the same `rstn`.

## Timing
- Write at edge N → `busy` at N+1, IDLE pops at N+1 edge, SETUP during N+1..N+2, `pr` rises at edge N+2.
- `pa` rise → `pa_s` two edges later → `pr` falls on the following edge (3 cycles worst case plus async slack).
- Per-symbol minimum with instantaneous `pa`: SETUP 1 + REQ 3 + RELEASE 3 = 7 cycles.
- Per-word minimum: 7·`NOC_WID`/2 + 1 (IDLE) = 57 cycles at `NOC_WID`=16.
- `ovf` sets on the edge of the dropped write. `ovf` clears on the edge of the control write.
- All outputs are registered. There is no combinational path from `pa` or `cfg_*` to any output.

## Structure
- Shared package `noc_pkg`:
  - `NOC_WID` and `REGIONAL_ADDR_WID` defaults.
  - FSM state enum `inj_state_t` {IDLE, SETUP, REQ, RELEASE}.
  - `SYM_WID`=2.
- One sub-module, `noc_inj_fifo`: synchronous FIFO with push/pop/full/empty and count, async active-low reset.
- The synchronizer is two flops inline in the top; it is not shared.

## Test plan
- Single word 0xA5C3, auto-ack model with 2-cycle `pa` delay → `pd` sequence 2,2,1,1,3,0,0,3, eight `pr` pulses, `busy` low after the last RELEASE.
- Six back-to-back data writes with `pa` held low → five accepted, one dropped, `ovf`=1. Release ack → five words emitted in order. Control write → `ovf`=0.
- Write to `slv_addr+2` and write with `cfg_stb`=0 → no push, `busy` stays 0.
- Randomized `pa` delay 0–20 cycles over 50 words → checker sees `pd` stable whenever `pr`=1 and payload matches written data.
- `rstn` low asynchronously during REQ of symbol 3 → `pr`, `pd`, `busy` go 0 without a clock edge. After release, a new 0x0001 write yields symbols 0,0,0,0,0,0,0,1.
- Spurious `pa`=1 while IDLE with an empty FIFO → no state change, `pr` stays 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the host-side NoC receive injector.
package noc_pkg;

    localparam int DEF_NOC_WID           = 16;
    localparam int DEF_REGIONAL_ADDR_WID = 11;
    localparam int SYM_WID               = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ,
        RELEASE
    } inj_state_t;

endpackage

// File: rtl/noc_inj_fifo.sv
// Word buffer between the configuration bus and the symbol serializer.
module noc_inj_fifo #(
    parameter int WID   = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [WID-1:0]             push_dat,
    input  logic                       pop,
    output logic [WID-1:0]             pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WID-1:0] mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/noc_rx_injector.sv
// Buffers addressed config-bus words and serializes them MSB-first as
// 2-bit symbols over a four-phase req/data/ack link.
module noc_rx_injector
    import noc_pkg::*;
#(
    parameter int NOC_WID           = DEF_NOC_WID,
    parameter int REGIONAL_ADDR_WID = DEF_REGIONAL_ADDR_WID,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NOC_WID-1:0]           cfg_dat,
    input  logic [REGIONAL_ADDR_WID-1:0] cfg_adr,
    input  logic                         cfg_stb,
    input  logic [REGIONAL_ADDR_WID-1:0] slv_addr,
    output logic                         pr,
    output logic [SYM_WID-1:0]           pd,
    input  logic                         pa,
    output logic                         busy,
    output logic                         ovf
);
    localparam int SYMS   = NOC_WID / SYM_WID;
    localparam int CNT_W  = $clog2(SYMS + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(SYMS - 1);

    logic                         data_wr;
    logic                         ctl_wr;
    logic [REGIONAL_ADDR_WID-1:0] ctl_addr;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic [NOC_WID-1:0]           fifo_dat;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [FCNT_W-1:0]            fifo_cnt;

    logic                         pa_meta;
    logic                         pa_s;

    inj_state_t                   state;
    inj_state_t                   state_next;
    logic [NOC_WID-1:0]           sreg;
    logic [NOC_WID-1:0]           sreg_next;
    logic [CNT_W-1:0]             cnt;
    logic [CNT_W-1:0]             cnt_next;
    logic                         pr_next;
    logic [SYM_WID-1:0]           pd_next;

    assign ctl_addr  = slv_addr + REGIONAL_ADDR_WID'(1);
    assign data_wr   = cfg_stb && (cfg_adr == slv_addr);
    assign ctl_wr    = cfg_stb && (cfg_adr == ctl_addr);
    assign fifo_push = data_wr && !fifo_full;

    noc_inj_fifo #(
        .WID   (NOC_WID),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (fifo_push),
        .push_dat (cfg_dat),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pa_meta <= 1'b0;
            pa_s    <= 1'b0;
        end else begin
            pa_meta <= pa;
            pa_s    <= pa_meta;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
        end else if (data_wr && fifo_full) begin
            ovf <= 1'b1;
        end else if (ctl_wr) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            pr    <= 1'b0;
            pd    <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            sreg  <= sreg_next;
            cnt   <= cnt_next;
            pr    <= pr_next;
            pd    <= pd_next;
            busy  <= (fifo_cnt != '0) || (state != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        sreg_next  = sreg;
        cnt_next   = cnt;
        fifo_pop   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    sreg_next  = fifo_dat;
                    cnt_next   = LAST_SYM;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = REQ;
            REQ: begin
                if (pa_s) state_next = RELEASE;
            end
            RELEASE: begin
                if (!pa_s) begin
                    if (cnt == '0) begin
                        state_next = IDLE;
                    end else begin
                        sreg_next  = sreg << SYM_WID;
                        cnt_next   = cnt - 1'b1;
                        state_next = SETUP;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so pr/pd come straight from flops.
    always_comb begin
        pr_next = (state_next == REQ);
        pd_next = pd;
        if (state_next == IDLE) begin
            pd_next = '0;
        end else if (state_next == SETUP) begin
            pd_next = sreg_next[NOC_WID-1 -: SYM_WID];
        end
    end

endmodule

// File: tb/tb_noc_rx_injector.sv
// Randomized scoreboard bench for noc_rx_injector with a behavioural PE ack model.
module tb_noc_rx_injector;

    localparam int W     = 16;
    localparam int AW    = 11;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [W-1:0]  cfg_dat;
    logic [AW-1:0] cfg_adr;
    logic          cfg_stb;
    logic [AW-1:0] slv_addr;
    logic          pr;
    logic [1:0]    pd;
    logic          pa;
    logic          busy;
    logic          ovf;

    logic          ack_pa;
    logic          spur_pa;
    logic          ack_hold;
    logic          ack_rand;
    int unsigned   ack_fixed;

    int            checks   = 0;
    int            failures = 0;
    logic [W-1:0]  exp_q[$];
    int            nsym      = 0;
    int            pr_rises  = 0;
    int            words_seen = 0;

    always #5 clk = ~clk;
    assign pa = ack_pa | spur_pa;

    noc_rx_injector #(
        .NOC_WID           (W),
        .REGIONAL_ADDR_WID (AW),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cfg_dat  (cfg_dat),
        .cfg_adr  (cfg_adr),
        .cfg_stb  (cfg_stb),
        .slv_addr (slv_addr),
        .pr       (pr),
        .pd       (pd),
        .pa       (pa),
        .busy     (busy),
        .ovf      (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Called at a negedge; the write is sampled at the following posedge.
    task automatic bus_wr(input logic [AW-1:0] adr, input logic [W-1:0] dat);
        cfg_stb = 1'b1;
        cfg_adr = adr;
        cfg_dat = dat;
        @(negedge clk);
        cfg_stb = 1'b0;
    endtask

    task automatic data_wr(input logic [W-1:0] dat, input bit accepted);
        if (accepted) exp_q.push_back(dat);
        bus_wr(slv_addr, dat);
    endtask

    task automatic wait_drain(input string name, input int unsigned limit);
        for (int unsigned i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
        chk({name, "_drain_timeout"}, exp_q.size(), 0);
        for (int unsigned i = 0; i < 40 && busy; i++) @(negedge clk);
        chk({name, "_busy_low"}, busy, 0);
    endtask

    // PE-side ack: raise pa some cycles after pr rises, drop it after pr falls.
    initial begin : ack_model
        int unsigned dly;
        int unsigned acnt;
        bit          phase;
        ack_pa = 1'b0;
        phase  = 1'b0;
        acnt   = 0;
        dly    = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                ack_pa = 1'b0;
                phase  = 1'b0;
                acnt   = 0;
            end else if (!phase) begin
                if (pr && !ack_hold) begin
                    if (acnt >= dly) begin
                        ack_pa = 1'b1;
                        phase  = 1'b1;
                        acnt   = 0;
                        dly    = ack_rand ? $urandom_range(20, 0) : ack_fixed;
                    end else acnt++;
                end
            end else if (!pr) begin
                if (acnt >= dly) begin
                    ack_pa = 1'b0;
                    phase  = 1'b0;
                    acnt   = 0;
                    dly    = ack_rand ? $urandom_range(20, 0) : ack_fixed;
                end else acnt++;
            end
        end
    end

    // Reassembles words from symbols captured at each pr rise and scores them.
    initial begin : monitor
        logic         pr_prev;
        logic [1:0]   pd_prev;
        logic [W-1:0] word;
        logic [W-1:0] expw;
        pr_prev = 1'b0;
        pd_prev = '0;
        word    = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                nsym    = 0;
                word    = '0;
                pr_prev = 1'b0;
            end else begin
                if (pr && pr_prev) chk("pd_stable_during_pr", pd, pd_prev);
                if (pr && !pr_prev) begin
                    pr_rises++;
                    word = {word[W-3:0], pd};
                    nsym++;
                    if (nsym == W / 2) begin
                        nsym = 0;
                        words_seen++;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_word", word, 32'hFFFF_FFFF);
                        end else begin
                            expw = exp_q.pop_front();
                            chk("word_payload", word, expw);
                        end
                    end
                end
                pr_prev = pr;
                pd_prev = pd;
            end
        end
    end

    initial begin : stimulus
        int rises0;
        logic [W-1:0] v;
        rstn      = 1'b0;
        cfg_stb   = 1'b0;
        cfg_adr   = '0;
        cfg_dat   = '0;
        slv_addr  = 11'h120;
        spur_pa   = 1'b0;
        ack_hold  = 1'b0;
        ack_rand  = 1'b0;
        ack_fixed = 2;

        repeat (3) @(negedge clk);
        chk("rst_pr", pr, 0);
        chk("rst_pd", pd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single word, 2-cycle ack delay.
        rises0 = pr_rises;
        data_wr(16'hA5C3, 1'b1);
        chk("t1_busy_rise", busy, 0);
        @(negedge clk);
        chk("t1_busy_next", busy, 1);
        wait_drain("t1", 1000);
        chk("t1_pr_pulses", pr_rises - rises0, 8);
        chk("t1_ovf", ovf, 0);

        // Overflow with ack held off.
        ack_hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_wr(W'(16'h1000 + i * 16'h0111), i < 5);
            if (i == 4) chk("t2_ovf_before_drop", ovf, 0);
        end
        chk("t2_ovf_set", ovf, 1);
        repeat (10) @(negedge clk);
        chk("t2_stalled_pr", pr, 1);
        chk("t2_stalled_busy", busy, 1);
        ack_hold = 1'b0;
        wait_drain("t2", 3000);
        chk("t2_ovf_sticky", ovf, 1);
        bus_wr(slv_addr + 11'd1, 16'hDEAD);
        chk("t2_ovf_clear", ovf, 0);

        // Writes that must not be accepted.
        bus_wr(slv_addr + 11'd2, 16'h5555);
        cfg_adr = slv_addr;
        cfg_dat = 16'h7777;
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("t3_busy", busy, 0);
        chk("t3_pr", pr, 0);
        chk("t3_ovf", ovf, 0);

        // Randomized ack delays over 50 words.
        ack_rand = 1'b1;
        for (int n = 0; n < 50; n++) begin
            for (int unsigned i = 0; i < 5000 && exp_q.size() >= DEPTH; i++) @(negedge clk);
            repeat ($urandom_range(3, 0)) @(negedge clk);
            v = W'($urandom);
            data_wr(v, exp_q.size() < DEPTH);
        end
        wait_drain("t4", 40000);
        ack_rand = 1'b0;

        // Asynchronous reset during REQ of the third symbol.
        data_wr(16'hFFFF, 1'b1);
        for (int unsigned i = 0; i < 200 && !(pr && nsym == 3); i++) @(negedge clk);
        chk("t5_reached_sym3", pr, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t5_async_pr", pr, 0);
        chk("t5_async_pd", pd, 0);
        chk("t5_async_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rises0 = pr_rises;
        data_wr(16'h0001, 1'b1);
        wait_drain("t5", 1000);
        chk("t5_pr_pulses", pr_rises - rises0, 8);

        // Spurious ack while idle.
        spur_pa = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t6_pr_idle", pr, 0);
        end
        chk("t6_busy_idle", busy, 0);
        spur_pa = 1'b0;
        repeat (4) @(negedge clk);
        data_wr(16'h1234, 1'b1);
        wait_drain("t6", 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
